uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Receive-side character buffer that sits directly downstream of the UART receiver.
//  - Captures each received character (rx_data, rx_perr) on the rx_done pulse.
//  - Presents characters to the host through a first-word-fall-through valid/ready port.
//  - Generates RTS hardware flow control with hysteresis, an overrun flag,
//    a character-timeout flag and an interrupt request.
// PARAMETERS
//  DEPTH     16  entries; power of two, >= 4
//  RTS_HI    12  level at/above which rts_n deasserts (1 = remote must stop)
//  RTS_LO     8  level at/below which rts_n reasserts (0 = ready); RTS_LO < RTS_HI <= DEPTH
//  IRQ_LVL    8  level at/above which irq asserts; 1..DEPTH
//  TO_TICKS 640  baud ticks of inactivity before timeout (40 bit times at 16x)
// PORTS
//  clk       in   1      clock
//  rst_n     in   1      asynchronous reset, active-low
//  tick      in   1      16x baud tick from the baud generator, 1-cycle pulse
//  rx_done   in   1      receiver character-complete pulse, 1 cycle
//  rx_data   in   8      received character, valid with rx_done
//  rx_perr   in   1      parity error for the character, valid with rx_done
//  rd_valid  out  1      head entry available (= !empty)
//  rd_ready  in   1      host accepts head entry
//  rd_data   out  8      head character; 0 when empty
//  rd_perr   out  1      head parity-error flag; 0 when empty
//  flush     in   1      synchronous clear of contents
//  ovr_clr   in   1      clear sticky overrun
//  level     out  $clog2(DEPTH)+1  current occupancy 0..DEPTH
//  full      out  1      level == DEPTH
//  overrun   out  1      sticky: a character was dropped while full
//  timeout   out  1      non-empty and idle for TO_TICKS ticks
//  rts_n     out  1      flow control to remote transmitter, active-low
//  irq       out  1      level>=IRQ_LVL | overrun | timeout
// BEHAVIOUR
//  Reset (async): pointers/level 0, rd_valid 0, full 0, overrun 0, timeout 0, rts_n 0, irq 0.
//  Storage: 9-bit entries {perr,data}; DEPTH x 9 register array.
//   - Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
//   - level is a separate counter.
//  push = rx_done & (!full | pop). pop = rd_valid & rd_ready.
//  Push is written at the clock edge; rd_valid rises the next cycle (1-cycle latency on an empty FIFO).
//  Pop advances the head at the edge; next entry appears the following cycle, with no bubble.
//  push & pop in the same cycle: level unchanged.
//   - When full, pop frees the slot, so the push is accepted and overrun does not set.
//   - When empty, no pop can occur (rd_valid=0); the push alone is accepted.
//  rx_done while full with no pop: character dropped, overrun<=1, contents unchanged.
//  overrun stays set until ovr_clr.
//   - ovr_clr coincident with a new drop: the set wins (overrun stays 1).
//  flush has priority over push/pop in the same cycle:
//   - Pointers and level go to 0; a coincident rx_done is discarded without setting overrun.
//   - timeout clears. overrun is NOT affected by flush.
//  Timeout counter (saturating, width >= $clog2(TO_TICKS+1)):
//   - Cleared on push, pop, flush, or when empty.
//   - Otherwise increments on tick.
//   - timeout is registered, = (cnt == TO_TICKS) & !empty.
//   - It drops the cycle after the next push/pop/flush.
//  rts_n is registered with hysteresis:
//   - Goes to 1 when next level >= RTS_HI.
//   - Goes to 0 when next level <= RTS_LO; otherwise it holds.
//  full and irq are registered from next-state values, so they are coherent with level in the same cycle.
//  rd_data and rd_perr are combinational from the head entry, masked to 0 when empty.
//  Reset mid-operation: all state is lost immediately and no partial push is kept.
// TESTING
//  1. After reset push 0x41 (perr 0): next cycle rd_valid=1, rd_data=0x41, level=1.
//     Pop with rd_ready=1: level=0, rd_valid=0.
//  2. Push 16 chars 0x00..0x0F with no reads: full=1, level=16, rts_n=1 once level hits 12.
//     A 17th push sets overrun=1 and irq=1; reading back gives 0x00..0x0F in order.
//  3. Full FIFO, rx_done and pop in the same cycle: level stays 16, overrun stays 0,
//     and the new character is read last.
//  4. Hysteresis: fill to 12 (rts_n=1), pop down to 9 (rts_n still 1), pop to 8 (rts_n=0).
//  5. One char stored, 639 ticks: timeout=0. 640th tick: timeout=1, irq=1.
//     Pop: timeout=0 the next cycle.
//  6. Push with rx_perr=1 -> rd_perr=1 at the head.
//     flush with a coincident rx_done: level=0, overrun unchanged.
//     Assert rst_n low mid-fill: all outputs at reset values.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// +--------------------------------------------------------------------------+
// | uart_rx_fifo: first-word-fall-through receive buffer behind the UART RX,  |
// | with RTS hysteresis, sticky overrun, character timeout and interrupt.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_rx_fifo #(
  parameter int DEPTH    = 16,
  parameter int RTS_HI   = 12,
  parameter int RTS_LO   = 8,
  parameter int IRQ_LVL  = 8,
  parameter int TO_TICKS = 640
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick,
  input  logic                     rx_done,
  input  logic [7:0]               rx_data,
  input  logic                     rx_perr,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [7:0]               rd_data,
  output logic                     rd_perr,
  input  logic                     flush,
  input  logic                     ovr_clr,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     overrun,
  output logic                     timeout,
  output logic                     rts_n,
  output logic                     irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(TO_TICKS + 1);

  localparam logic [LW-1:0] C_DEPTH   = LW'(DEPTH);
  localparam logic [LW-1:0] C_RTS_HI  = LW'(RTS_HI);
  localparam logic [LW-1:0] C_RTS_LO  = LW'(RTS_LO);
  localparam logic [LW-1:0] C_IRQ_LVL = LW'(IRQ_LVL);
  localparam logic [CW-1:0] C_TO_MAX  = CW'(TO_TICKS);

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          overrun_q, overrun_d;
  logic          timeout_q, timeout_d;
  logic          rts_n_q, rts_n_d;
  logic          irq_q, irq_d;

  logic          empty;
  logic          do_push;
  logic          do_pop;
  logic          drop;
  logic          wr_en;
  logic [8:0]    head;

  always_comb begin
    empty   = (level_q == '0);
    do_pop  = ~empty & rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    do_push = rx_done & (~full_q | do_pop);
    drop    = rx_done & full_q & ~do_pop & ~flush;
    wr_en   = do_push & ~flush;

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end

    if (drop)         overrun_d = 1'b1;
    else if (ovr_clr) overrun_d = 1'b0;
    else              overrun_d = overrun_q;

    if (flush | do_push | do_pop | empty)
      cnt_d = '0;
    else if (tick && cnt_q != C_TO_MAX)
      cnt_d = cnt_q + CW'(1);
    else
      cnt_d = cnt_q;

    timeout_d = (cnt_d == C_TO_MAX) & (level_d != '0);

    if (level_d >= C_RTS_HI)      rts_n_d = 1'b1;
    else if (level_d <= C_RTS_LO) rts_n_d = 1'b0;
    else                          rts_n_d = rts_n_q;

    full_d = (level_d == C_DEPTH);
    irq_d  = (level_d >= C_IRQ_LVL) | overrun_d | timeout_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      rts_n_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
      rts_n_q   <= rts_n_d;
      irq_q     <= irq_d;
    end
  end

  // Storage needs no reset: the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= {rx_perr, rx_data};
  end

  assign head     = mem_q[rptr_q];
  assign rd_valid = ~empty;
  assign rd_data  = empty ? 8'h00 : head[7:0];
  assign rd_perr  = empty ? 1'b0  : head[8];
  assign level    = level_q;
  assign full     = full_q;
  assign overrun  = overrun_q;
  assign timeout  = timeout_q;
  assign rts_n    = rts_n_q;
  assign irq      = irq_q;

endmodule

`default_nettype wire
